// File: rtl/axi_lite_bram_slave.sv
// rtl/axi_lite_bram_slave.sv - AXI4-Lite slave serialising single-beat reads/writes onto one BRAM port
//
// Purpose:
//   Accepts one AXI4-Lite transaction at a time and maps it onto a single-port
//   BRAM. A write needs AW and W presented together. When a write and a read
//   contend in the same cycle, a round-robin flag alternates the winner.
//   Accesses at or above 4*C_MEM_DEPTH bytes answer SLVERR and never touch the BRAM.
//
// Ports:
//   ACLK, ARESET                 clock, synchronous active-high reset
//   S_AXI_AW*                    write address channel (AWPROT ignored)
//   S_AXI_W*                     write data channel with byte strobes
//   S_AXI_B*                     write response channel (OKAY=00, SLVERR=10)
//   S_AXI_AR*                    read address channel (ARPROT ignored)
//   S_AXI_R*                     read data/response channel
//   bram_en, bram_we             BRAM enable and byte write enables
//   bram_addr                    BRAM word address (AXI byte address >> 2)
//   bram_wrdata, bram_rddata     BRAM write data / read data
//
// Parameters:
//   C_S_AXI_ADDR_WIDTH           AXI byte-address width
//   C_MEM_DEPTH                  BRAM depth in 32-bit words
//   C_BRAM_RD_LATENCY            BRAM read latency in cycles (1 or 2)

module axi_lite_bram_slave #(
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_MEM_DEPTH        = 1024,
  parameter int C_BRAM_RD_LATENCY  = 1
) (
  input  logic                             ACLK,
  input  logic                             ARESET,

  input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_AWADDR,
  input  logic [2:0]                       S_AXI_AWPROT,
  input  logic                             S_AXI_AWVALID,
  output logic                             S_AXI_AWREADY,

  input  logic [31:0]                      S_AXI_WDATA,
  input  logic [3:0]                       S_AXI_WSTRB,
  input  logic                             S_AXI_WVALID,
  output logic                             S_AXI_WREADY,

  output logic [1:0]                       S_AXI_BRESP,
  output logic                             S_AXI_BVALID,
  input  logic                             S_AXI_BREADY,

  input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_ARADDR,
  input  logic [2:0]                       S_AXI_ARPROT,
  input  logic                             S_AXI_ARVALID,
  output logic                             S_AXI_ARREADY,

  output logic [31:0]                      S_AXI_RDATA,
  output logic [1:0]                       S_AXI_RRESP,
  output logic                             S_AXI_RVALID,
  input  logic                             S_AXI_RREADY,

  output logic                             bram_en,
  output logic [3:0]                       bram_we,
  output logic [$clog2(C_MEM_DEPTH)-1:0]   bram_addr,
  output logic [31:0]                      bram_wrdata,
  input  logic [31:0]                      bram_rddata
);

  localparam int          BRAM_AW     = $clog2(C_MEM_DEPTH);
  localparam logic [31:0] MEM_BYTES   = 32'(4 * C_MEM_DEPTH);
  localparam logic [1:0]  RD_LAT      = 2'(C_BRAM_RD_LATENCY);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_EXEC,
    ST_WR_RESP,
    ST_RD_WAIT,
    ST_RD_RESP
  } state_t;

  state_t               state_q;

  logic                 awready_q;
  logic                 wready_q;
  logic                 arready_q;
  logic                 bvalid_q;
  logic [1:0]           bresp_q;
  logic                 rvalid_q;
  logic [1:0]           rresp_q;
  logic [31:0]          rdata_q;

  logic                 bram_en_q;
  logic [3:0]           bram_we_q;
  logic [BRAM_AW-1:0]   bram_addr_q;
  logic [31:0]          bram_wrdata_q;

  // Set when the in-flight access is outside the memory window.
  logic                 err_q;
  // Cycles still to wait in RD_WAIT before bram_rddata is valid.
  logic [1:0]           rd_cnt_q;
  // Round-robin flag: 1 means a write wins the next contested arbitration.
  logic                 pref_wr_q;

  logic                 wr_eligible;
  logic                 rd_eligible;
  logic                 aw_in_range;
  logic                 ar_in_range;
  logic [BRAM_AW-1:0]   aw_word;
  logic [BRAM_AW-1:0]   ar_word;

  // Protection bits carry no meaning for a plain memory window.
  logic                 unused_prot;

  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  assign wr_eligible = S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_eligible = S_AXI_ARVALID;

  assign aw_in_range = 32'(S_AXI_AWADDR) < MEM_BYTES;
  assign ar_in_range = 32'(S_AXI_ARADDR) < MEM_BYTES;

  // Dropping the two byte-offset bits word-aligns any unaligned address.
  assign aw_word = BRAM_AW'(S_AXI_AWADDR >> 2);
  assign ar_word = BRAM_AW'(S_AXI_ARADDR >> 2);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= ST_IDLE;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      arready_q     <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= RESP_OKAY;
      rvalid_q      <= 1'b0;
      rresp_q       <= RESP_OKAY;
      rdata_q       <= 32'h0;
      bram_en_q     <= 1'b0;
      bram_we_q     <= 4'h0;
      bram_addr_q   <= '0;
      bram_wrdata_q <= 32'h0;
      err_q         <= 1'b0;
      rd_cnt_q      <= 2'd0;
      pref_wr_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (awready_q) begin
            // AW and W handshake on this edge; the master holds both valid
            // until it sees ready, so the channels are captured here.
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            bram_en_q     <= aw_in_range;
            bram_we_q     <= aw_in_range ? S_AXI_WSTRB : 4'h0;
            bram_addr_q   <= aw_word;
            bram_wrdata_q <= S_AXI_WDATA;
            err_q         <= !aw_in_range;
            state_q       <= ST_WR_EXEC;
          end else if (arready_q) begin
            // AR handshake on this edge; the BRAM read is issued next cycle.
            arready_q   <= 1'b0;
            bram_en_q   <= ar_in_range;
            bram_we_q   <= 4'h0;
            bram_addr_q <= ar_word;
            err_q       <= !ar_in_range;
            rd_cnt_q    <= RD_LAT;
            state_q     <= ST_RD_WAIT;
          end else if (wr_eligible && (!rd_eligible || pref_wr_q)) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            // The flag only moves when both sides actually contended.
            if (rd_eligible) begin
              pref_wr_q <= 1'b0;
            end
          end else if (rd_eligible) begin
            arready_q <= 1'b1;
            if (wr_eligible) begin
              pref_wr_q <= 1'b1;
            end
          end
        end

        ST_WR_EXEC: begin
          bram_en_q <= 1'b0;
          bram_we_q <= 4'h0;
          bvalid_q  <= 1'b1;
          bresp_q   <= err_q ? RESP_SLVERR : RESP_OKAY;
          state_q   <= ST_WR_RESP;
        end

        ST_WR_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            state_q  <= ST_IDLE;
          end
        end

        ST_RD_WAIT: begin
          bram_en_q <= 1'b0;
          if (rd_cnt_q == 2'd0) begin
            // Out-of-range reads follow the same timing but return zero.
            rvalid_q <= 1'b1;
            rdata_q  <= err_q ? 32'h0 : bram_rddata;
            rresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
            state_q  <= ST_RD_RESP;
          end else begin
            rd_cnt_q <= rd_cnt_q - 2'd1;
          end
        end

        ST_RD_RESP: begin
          if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            state_q  <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  assign bram_en     = bram_en_q;
  assign bram_we     = bram_we_q;
  assign bram_addr   = bram_addr_q;
  assign bram_wrdata = bram_wrdata_q;

endmodule
